prio_arb_enc: RTL

Registered, parametrised priority encoder with a valid/ack output handshake and two selectable modes: fixed priority (highest index wins) or round-robin. It samples an N-bit request vector on a strobe. It presents the winning index, plus a one-hot grant, until the consumer acknowledges. It is the clocked, N-wide successor to the team's combinational 8-to-3 priority encoder. It sits between request sources and a single shared consumer.

---
 rtl/prio_arb_pkg.sv | 6 +
 rtl/prio_arb_enc_pick.sv | 29 ++
 rtl/prio_arb_enc.sv | 73 +++++++
 3 files changed

// File: rtl/prio_arb_pkg.sv
// prio_arb_pkg: shared mode constants and FSM state type for the priority arbiter
package prio_arb_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
  typedef enum logic {ST_EMPTY, ST_HOLD} state_t;
endpackage

// File: rtl/prio_arb_enc_pick.sv
// prio_pick: combinational winner select, highest-index fixed or round-robin from ptr
module prio_pick
  import prio_arb_pkg::*;
#(
  parameter int N = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          mode,
  output logic          any,
  output logic [IW-1:0] idx
);
  logic [2*N-1:0] dbl;
  assign any = |req;
  always_comb begin
    dbl = '0;
    for (int i = 0; i < N; i++) begin
      dbl[i] = req[i] && (i >= int'(ptr));
      dbl[N+i] = req[i];
    end
    idx = '0;
    if (mode == MODE_RR) begin
      for (int i = 2*N-1; i >= 0; i--) if (dbl[i]) idx = IW'(i % N);
    end else begin
      for (int i = 0; i < N; i++) if (req[i]) idx = IW'(i);
    end
  end
endmodule

// File: rtl/prio_arb_enc.sv
// prio_arb_enc: registered priority encoder with valid/ack hold and fixed or round-robin mode
module prio_arb_enc
  import prio_arb_pkg::*;
#(
  parameter int N = 8,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          mode,
  input  logic          en,
  input  logic          ack,
  output logic          out_valid,
  output logic [IW-1:0] out_idx,
  output logic [N-1:0]  out_onehot,
  output logic          idle
);
  state_t state_q, state_d;
  logic [IW-1:0] out_idx_q, out_idx_d, ptr_q, ptr_d, pick_idx;
  logic [N-1:0] out_onehot_q, out_onehot_d;
  logic idle_q, idle_d, mode_q, mode_d, pick_any, hold, done, load;
  assign hold = state_q == ST_HOLD;
  assign done = hold && ack;
  assign load = (!hold || ack) && en;
  assign ptr_d = (done && mode_q == MODE_RR) ?
                 ((out_idx_q == IW'(N-1)) ? '0 : out_idx_q + IW'(1)) : ptr_q;
  prio_pick #(.N(N), .IW(IW)) u_pick (
    .req(req),
    .ptr(ptr_d),
    .mode(mode),
    .any(pick_any),
    .idx(pick_idx)
  );
  always_comb begin
    state_d = state_q;
    out_idx_d = out_idx_q;
    out_onehot_d = out_onehot_q;
    idle_d = idle_q;
    mode_d = mode_q;
    if (load) begin
      state_d = pick_any ? ST_HOLD : ST_EMPTY;
      out_idx_d = pick_any ? pick_idx : out_idx_q;
      out_onehot_d = pick_any ? N'(1) << pick_idx : '0;
      idle_d = !pick_any;
      mode_d = mode;
    end else if (done) begin
      state_d = ST_EMPTY;
      out_onehot_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      out_idx_q <= '0;
      out_onehot_q <= '0;
      idle_q <= 1'b1;
      mode_q <= MODE_FIXED;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      out_idx_q <= out_idx_d;
      out_onehot_q <= out_onehot_d;
      idle_q <= idle_d;
      mode_q <= mode_d;
      ptr_q <= ptr_d;
    end
  end
  assign out_valid = hold;
  assign out_idx = out_idx_q;
  assign out_onehot = out_onehot_q;
  assign idle = idle_q;
endmodule
